qspi_axil_wr_dma: RTL and testbench

Single-channel write DMA that drains a 32-bit word stream (QSPI read-data path) into memory through an AXI4-Lite master write port. It sits directly upstream of `axi4_ram_slave` and drives that block's AW/W/B channels, one transaction outstanding at a time. Software-side control is a start pulse with a base address and a word count. Completion is a `done` pulse plus a sticky `error` flag.

---
 rtl/qspi_axil_wr_dma.sv | 133 +++++++++++++
 tb/tb_qspi_axil_wr_dma.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_axil_wr_dma.sv
// Write DMA: drains a 32-bit stream into memory over an AXI4-Lite master write port.
// Keeps one AW/W/B transaction in flight and signals completion with a done pulse and a sticky error flag.
module qspi_axil_wr_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  words_done,
    input  logic [31:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RESP, DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 aw_ok;
    logic                 w_ok;

    // A channel counts as accepted once its valid has dropped or its handshake is happening now.
    assign aw_ok = !awvalid || awready;
    assign w_ok  = !wvalid || wready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
            s_ready    <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= 4'h0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        awaddr     <= base_addr & ~ADDR_WIDTH'(3);
                        remaining  <= word_count;
                        words_done <= '0;
                        error      <= 1'b0;
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            busy    <= 1'b1;
                            s_ready <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        wdata   <= s_data;
                        s_ready <= 1'b0;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        wstrb   <= 4'hF;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                        wstrb  <= 4'h0;
                    end
                    if (aw_ok && w_ok) begin
                        state  <= RESP;
                        bready <= 1'b1;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp == 2'b00) begin
                            words_done <= words_done + LEN_WIDTH'(1);
                            awaddr     <= awaddr + ADDR_WIDTH'(4);
                            remaining  <= remaining - LEN_WIDTH'(1);
                            if (remaining == LEN_WIDTH'(1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state   <= FETCH;
                                s_ready <= 1'b1;
                            end
                        end else begin
                            // Any non-OKAY response aborts the rest of the transfer.
                            error <= 1'b1;
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_axil_wr_dma.sv
// Bench for qspi_axil_wr_dma: behavioural AXI4-Lite write slave with a 256-word memory,
// a stream source fed from a queue, and a transfer-level reference model of memory contents.
module tb_qspi_axil_wr_dma;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] word_count = '0;
    logic          busy, done, error;
    logic [LW-1:0] words_done;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;

    qspi_axil_wr_dma #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .words_done(words_done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    logic [90:0] all_out;
    assign all_out = {busy, done, error, words_done, s_ready, awvalid, wvalid, bready,
                      awaddr, wdata, wstrb};

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] mem[256];
    logic [31:0] exp_mem[256];
    logic [31:0] stream_q[$];
    logic [31:0] fixed_q[$];

    int aw_delay = 0, w_delay = 0, b_delay = 0, err_beat = -1;
    bit throttle = 0, tog = 0;
    bit aw_hs = 0, w_hs = 0, b_pending = 0, b_err = 0, aw_act = 0, w_act = 0;
    logic [AW-1:0] cap_addr, aw_first;
    logic [31:0]   cap_data, w_first;
    int aw_wait = 0, w_wait = 0, b_wait = 0, beat_idx = 0;
    int aw_beats = 0, w_beats = 0, consumed = 0, viol = 0, cyc = 0, last_b_cyc = -1;

    // Slave/monitor: observes handshakes on the rising edge using pre-edge values.
    always @(posedge clk) begin
        cyc++;
        if (!resetn) begin
            aw_hs = 0; w_hs = 0; b_pending = 0; aw_act = 0; w_act = 0;
        end else begin
            if (s_ready && (awvalid || wvalid || bready || !busy)) viol++;
            if (awvalid && aw_hs) viol++;
            if (wvalid && w_hs) viol++;
            if (wvalid && wstrb !== 4'hF) viol++;
            if (awvalid && !aw_hs) begin
                if (!aw_act) begin aw_act = 1; aw_first = awaddr; end
                else if (awaddr !== aw_first) viol++;
            end
            if (wvalid && !w_hs) begin
                if (!w_act) begin w_act = 1; w_first = wdata; end
                else if (wdata !== w_first) viol++;
            end
            if (s_valid && s_ready) begin
                if (stream_q.size() > 0) void'(stream_q.pop_front());
                consumed++;
            end
            if (bvalid && bready) begin
                b_pending = 0; aw_hs = 0; w_hs = 0; last_b_cyc = cyc;
            end
            if (awvalid && awready) begin
                if (aw_hs || b_pending) viol++;
                aw_hs = 1; aw_act = 0; cap_addr = awaddr; aw_beats++;
            end
            if (wvalid && wready) begin
                if (w_hs || b_pending) viol++;
                w_hs = 1; w_act = 0; cap_data = wdata; w_beats++;
            end
            if (aw_hs && w_hs && !b_pending) begin
                b_pending = 1;
                b_err = (beat_idx == err_beat);
                if (!b_err) mem[cap_addr[9:2]] = cap_data;
                beat_idx++;
            end
        end
    end

    // Slave and stream drivers update on the falling edge.
    always @(negedge clk) begin
        if (!resetn) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
            aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (awvalid && !aw_hs) begin awready = (aw_wait >= aw_delay); aw_wait++; end
            else begin awready = 0; aw_wait = 0; end
            if (wvalid && !w_hs) begin wready = (w_wait >= w_delay); w_wait++; end
            else begin wready = 0; w_wait = 0; end
            if (b_pending) begin
                bvalid = (b_wait >= b_delay); b_wait++; bresp = b_err ? 2'b10 : 2'b00;
            end else begin
                bvalid = 0; b_wait = 0; bresp = 2'b00;
            end
        end
        if (stream_q.size() > 0 && (!throttle || tog)) begin
            s_valid = 1; s_data = stream_q[0];
        end else begin
            s_valid = 0;
        end
        tog = ~tog;
    end

    task automatic do_transfer(input logic [AW-1:0] base, input int count, input int errb,
                               input bit thr, input int ad, input int wd, input int bd,
                               input int extra);
        logic [31:0] words[$];
        int n_ok, exp_cons, budget, pulses, first_done, c, bad;
        bit exp_err;
        @(negedge clk);
        aw_delay = ad; w_delay = wd; b_delay = bd; throttle = thr; err_beat = errb;
        beat_idx = 0; aw_beats = 0; w_beats = 0; consumed = 0; viol = 0; last_b_cyc = -1;
        stream_q.delete();
        for (int i = 0; i < count + extra; i++) begin
            words.push_back(i < fixed_q.size() ? fixed_q[i] : $urandom);
            stream_q.push_back(words[i]);
        end
        fixed_q.delete();
        n_ok = (errb >= 0 && errb < count) ? errb : count;
        exp_err = (n_ok < count);
        exp_cons = exp_err ? n_ok + 1 : count;
        for (int i = 0; i < n_ok; i++) exp_mem[((base >> 2) + i) % 256] = words[i];
        start = 1; base_addr = base; word_count = LW'(count);
        @(negedge clk);
        start = 0;
        n_total++;
        if ({error, busy, done} !== {1'b0, count != 0, count == 0})
            $display("FAIL start_resp: error/busy/done=%b required %b", {error, busy, done},
                     {1'b0, count != 0, count == 0});
        else n_pass++;
        budget = 20 + count * (ad + wd + bd + 8);
        pulses = 0; first_done = -1; c = 0;
        while (c < budget) begin
            if (done) begin pulses++; if (first_done < 0) first_done = cyc; end
            if (first_done >= 0 && cyc >= first_done + 2) break;
            @(negedge clk);
            c++;
        end
        n_total++;
        if (first_done < 0) $display("FAIL done_timeout: no done within %0d cycles", budget);
        else n_pass++;
        n_total++;
        if (pulses != 1) $display("FAIL done_pulses: got %0d required 1", pulses);
        else n_pass++;
        n_total++;
        if (words_done !== LW'(n_ok)) $display("FAIL words_done: got %0d required %0d", words_done, n_ok);
        else n_pass++;
        n_total++;
        if (error !== exp_err) $display("FAIL error_flag: got %b required %b", error, exp_err);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL mem_contents: %0d words differ, required 0", bad);
        else n_pass++;
        n_total++;
        if (consumed != exp_cons || stream_q.size() != count + extra - exp_cons)
            $display("FAIL stream_consumed: got %0d (left %0d) required %0d (left %0d)",
                     consumed, stream_q.size(), exp_cons, count + extra - exp_cons);
        else n_pass++;
        n_total++;
        if (aw_beats != exp_cons || w_beats != exp_cons)
            $display("FAIL axi_beats: aw=%0d w=%0d required %0d", aw_beats, w_beats, exp_cons);
        else n_pass++;
        n_total++;
        if (viol != 0) $display("FAIL protocol: %0d violations required 0", viol);
        else n_pass++;
        if (count > 0) begin
            n_total++;
            if (first_done != last_b_cyc)
                $display("FAIL resp_to_done: done cycle %0d required %0d", first_done, last_b_cyc);
            else n_pass++;
        end
        n_total++;
        if ({busy, done, s_ready, awvalid, wvalid, bready} !== 6'b0)
            $display("FAIL idle_after: busy/done/s_ready/awv/wv/bready=%b required 000000",
                     {busy, done, s_ready, awvalid, wvalid, bready});
        else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (3) @(negedge clk);
        n_total++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h required 0", all_out);
        else n_pass++;
        resetn = 1;
    endtask

    task automatic test_basic();
        fixed_q = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEBABE};
        do_transfer(32'h0, 3, -1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_misaligned();
        do_transfer(32'h13, 2, -1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_throttle();
        do_transfer(32'h40, 4, -1, 1, 0, 0, 0, 1);
    endtask

    task automatic test_delays();
        do_transfer(32'h80, 3, -1, 0, 3, 0, 0, 0);
        do_transfer(32'hA0, 3, -1, 0, 0, 3, 1, 0);
    endtask

    task automatic test_error();
        do_transfer(32'h100, 5, 1, 0, 1, 0, 1, 0);
        repeat (3) @(negedge clk);
        n_total++;
        if (error !== 1'b1) $display("FAIL error_sticky: got %b required 1", error);
        else n_pass++;
        do_transfer(32'h120, 2, -1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_zero_and_reset();
        int c;
        do_transfer(32'h200, 0, -1, 0, 0, 0, 0, 2);
        @(negedge clk);
        aw_delay = 8; w_delay = 0; b_delay = 0; throttle = 0; err_beat = -1;
        stream_q.delete();
        for (int i = 0; i < 3; i++) stream_q.push_back($urandom);
        start = 1; base_addr = 32'h300; word_count = LW'(3);
        @(negedge clk);
        start = 0;
        c = 0;
        while (!awvalid && c < 20) begin @(negedge clk); c++; end
        n_total++;
        if (!awvalid) $display("FAIL reach_write: awvalid=%b required 1", awvalid);
        else n_pass++;
        resetn = 0;
        @(negedge clk);
        n_total++;
        if (all_out !== '0) $display("FAIL midreset_outputs: got %h required 0", all_out);
        else n_pass++;
        stream_q.delete();
        resetn = 1;
        do_transfer(32'h304, 3, -1, 0, 1, 2, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int cnt, eb;
            cnt = $urandom_range(1, 8);
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
            do_transfer(AW'($urandom_range(0, 800)), cnt, eb, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 2));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        test_reset();
        test_basic();
        test_misaligned();
        test_throttle();
        test_delays();
        test_error();
        test_zero_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
